// File: rtl/sampler_pkg.sv
// Shared defaults and read-side state encoding for the FFT sample framer.
package sampler_pkg;

    localparam int DEF_SAMPLE_W  = 12;
    localparam int DEF_OUT_W     = 16;
    localparam int DEF_FRAME_LEN = 512;
    localparam int DEF_DECIM     = 8;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_START   = 2'd1,
        RD_STREAM  = 2'd2,
        RD_RELEASE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/framer_pair_ram.sv
// Two-bank ping-pong sample-pair store: one write port, one registered read port.
module framer_pair_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 24,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    // Write port; bank select is the address MSB.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Registered read port, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/fft_framer.sv
// Decimates an audio stream, packs sample pairs into ping-pong banks and
// streams each full bank to a radix-2 FFT as (x0,x1,x2,x3) operand pairs.
module fft_framer
    import sampler_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int DECIM     = DEF_DECIM,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                fft_busy,
    output logic                fft_next,
    output logic [OUT_W-1:0]    x0,
    output logic [OUT_W-1:0]    x1,
    output logic [OUT_W-1:0]    x2,
    output logic [OUT_W-1:0]    x3,
    output logic                out_valid,
    output logic                overrun
);

    localparam int HALF = FRAME_LEN / 2;
    localparam int AW   = $clog2(HALF);
    localparam int DCW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WW   = 2 * SAMPLE_W;
    localparam logic [AW-1:0]  LAST_ADDR = AW'(HALF - 1);
    localparam logic [DCW-1:0] LAST_DEC  = DCW'(DECIM - 1);

    function automatic logic [OUT_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
        return {{(OUT_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    logic [DCW-1:0]      dec_cnt;
    logic                odd_phase;
    logic [SAMPLE_W-1:0] even_hold;
    logic                wr_bank;
    logic [AW-1:0]       wr_addr;
    logic [1:0]          full;
    rd_state_t           state;
    rd_state_t           next_state;
    logic                rd_bank;
    logic [AW-1:0]       rd_cnt;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [WW-1:0]       rd_data;
    logic                accept;
    logic                release_now;
    logic [1:0]          release_mask;
    logic [1:0]          fill_mask;
    logic [1:0]          full_eff;
    logic                blocked;
    logic                wr_en;
    logic                bank_fill;

    // A release in this cycle is visible to the write side before it decides to stall.
    assign accept       = sample_valid && (dec_cnt == {DCW{1'b0}});
    assign release_now  = (state == RD_RELEASE);
    assign release_mask = release_now ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign full_eff     = full & ~release_mask;
    assign blocked      = full_eff[wr_bank];
    assign wr_en        = accept && !blocked && odd_phase;
    assign bank_fill    = wr_en && (wr_addr == LAST_ADDR);
    assign fill_mask    = bank_fill ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

    // Decimation, pair assembly, bank filling and overrun tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt   <= {DCW{1'b0}};
            odd_phase <= 1'b0;
            even_hold <= {SAMPLE_W{1'b0}};
            wr_bank   <= 1'b0;
            wr_addr   <= {AW{1'b0}};
            full      <= 2'b00;
            overrun   <= 1'b0;
        end else begin
            if (sample_valid) begin
                dec_cnt <= (dec_cnt == LAST_DEC) ? {DCW{1'b0}} : dec_cnt + 1'b1;
            end
            if (accept) begin
                if (blocked) begin
                    overrun <= 1'b1;
                end else if (!odd_phase) begin
                    even_hold <= sample_in;
                    odd_phase <= 1'b1;
                end else begin
                    odd_phase <= 1'b0;
                    wr_addr   <= bank_fill ? {AW{1'b0}} : wr_addr + 1'b1;
                    if (bank_fill) begin
                        wr_bank <= ~wr_bank;
                    end
                end
            end
            full <= full_eff | fill_mask;
        end
    end

    // Read sequencing; banks are consumed in the same alternating order they fill.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_addr    = {AW{1'b0}};
        case (state)
            RD_IDLE: begin
                if (full[rd_bank] && !fft_busy) begin
                    next_state = RD_START;
                end else begin
                    next_state = RD_IDLE;
                end
            end
            RD_START: begin
                rd_en      = 1'b1;
                next_state = RD_STREAM;
            end
            RD_STREAM: begin
                rd_en   = 1'b1;
                rd_addr = rd_cnt + 1'b1;
                if (rd_cnt == LAST_ADDR) begin
                    next_state = RD_RELEASE;
                end else begin
                    next_state = RD_STREAM;
                end
            end
            RD_RELEASE: next_state = RD_IDLE;
            default:    next_state = RD_IDLE;
        endcase
    end

    // Read state register and registered frame-control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RD_IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= {AW{1'b0}};
            fft_next  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            rd_cnt    <= (state == RD_STREAM) ? rd_cnt + 1'b1 : {AW{1'b0}};
            fft_next  <= (next_state == RD_START);
            out_valid <= (next_state == RD_STREAM);
            if (release_now) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    framer_pair_ram #(
        .DEPTH  (HALF),
        .DATA_W (WW),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data ({sample_in, even_hold}),
        .rd_en   (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Stale RAM output is masked whenever no pair is being presented.
    assign x0 = out_valid ? sext(rd_data[SAMPLE_W-1:0]) : {OUT_W{1'b0}};
    assign x2 = out_valid ? sext(rd_data[WW-1:SAMPLE_W]) : {OUT_W{1'b0}};
    assign x1 = {OUT_W{1'b0}};
    assign x3 = {OUT_W{1'b0}};

endmodule

// File: tb/tb_fft_framer.sv
// Bench for fft_framer: frame-level reference model for a DECIM=2 instance and
// a vector table for a DECIM=1 instance.
module tb_fft_framer;

    localparam int FL   = 8;
    localparam int HALF = FL / 2;
    localparam int SW   = 12;
    localparam int OW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_reset, a_valid, a_busy, a_next, a_ovalid, a_overrun;
    logic [SW-1:0] a_in;
    logic [OW-1:0] a_x0, a_x1, a_x2, a_x3;
    logic          b_reset, b_valid, b_busy, b_next, b_ovalid, b_overrun;
    logic [SW-1:0] b_in;
    logic [OW-1:0] b_x0, b_x1, b_x2, b_x3;

    fft_framer #(.FRAME_LEN(FL), .DECIM(2), .SAMPLE_W(SW), .OUT_W(OW)) dut_a (
        .clk(clk), .reset(a_reset), .sample_in(a_in), .sample_valid(a_valid),
        .fft_busy(a_busy), .fft_next(a_next), .x0(a_x0), .x1(a_x1), .x2(a_x2),
        .x3(a_x3), .out_valid(a_ovalid), .overrun(a_overrun)
    );

    fft_framer #(.FRAME_LEN(FL), .DECIM(1), .SAMPLE_W(SW), .OUT_W(OW)) dut_b (
        .clk(clk), .reset(b_reset), .sample_in(b_in), .sample_valid(b_valid),
        .fft_busy(b_busy), .fft_next(b_next), .x0(b_x0), .x1(b_x1), .x2(b_x2),
        .x3(b_x3), .out_valid(b_ovalid), .overrun(b_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] sx(input logic [SW-1:0] s);
        return OW'($signed(s));
    endfunction

    // Reference model: accepted samples, pending frames, frames held in banks.
    logic [SW-1:0] part_q[$];
    logic [SW-1:0] frame_q[$];
    int held, strobe_n, widx;
    bit rel_pending, exp_ovr, prev_next;

    task automatic mon_a();
        if (a_reset) begin
            chk("reset_outputs", {a_next, a_ovalid, a_overrun, |{a_x0, a_x1, a_x2, a_x3}}, 64'd0);
            part_q.delete(); frame_q.delete();
            held = 0; strobe_n = 0; widx = 0;
            rel_pending = 1'b0; exp_ovr = 1'b0; prev_next = 1'b0;
        end else begin
            if (rel_pending) begin
                held--;
                rel_pending = 1'b0;
            end
            chk("overrun", a_overrun, exp_ovr);
            chk("imag_zero", {a_x1, a_x3}, 64'd0);
            if (prev_next) chk("stream_after_next", a_ovalid, 1);
            if (a_next) chk("next_with_frame", (frame_q.size() >= FL) && (widx == 0), 1);
            if (a_ovalid) begin
                if (frame_q.size() < FL) begin
                    chk("spurious_valid", a_ovalid, 0);
                end else begin
                    chk("x0_data", a_x0, sx(frame_q[2*widx]));
                    chk("x2_data", a_x2, sx(frame_q[2*widx+1]));
                    widx++;
                    if (widx == HALF) begin
                        for (int k = 0; k < FL; k++) void'(frame_q.pop_front());
                        widx = 0;
                        rel_pending = 1'b1;
                    end
                end
            end else begin
                if (widx != 0) chk("stream_gap", a_ovalid, 1);
                chk("idle_zero", {a_x0, a_x2}, 64'd0);
            end
            prev_next = a_next;
            if (a_valid) begin
                if (strobe_n % 2 == 0) begin
                    if (held == 2) begin
                        exp_ovr = 1'b1;
                    end else begin
                        part_q.push_back(a_in);
                        if (part_q.size() == FL) begin
                            foreach (part_q[k]) frame_q.push_back(part_q[k]);
                            part_q.delete();
                            held++;
                        end
                    end
                end
                strobe_n++;
            end
        end
    endtask

    task automatic step_a(input logic v, input logic [SW-1:0] d, input logic busy);
        @(posedge clk); #1;
        a_valid = v; a_in = d; a_busy = busy; b_valid = 1'b0;
        @(negedge clk);
        mon_a();
    endtask

    task automatic step_b(input logic v, input logic [SW-1:0] d);
        @(posedge clk); #1;
        b_valid = v; b_in = d; a_valid = 1'b0; a_busy = 1'b0;
        @(negedge clk);
        mon_a();
    endtask

    task automatic hold_reset_a();
        a_reset = 1'b1; a_valid = 1'b0; a_busy = 1'b0;
        @(negedge clk); mon_a();
        @(posedge clk); #1; @(negedge clk); mon_a();
        @(posedge clk); #1; a_reset = 1'b0;
        @(negedge clk); mon_a();
    endtask

    task automatic reset_a();
        @(posedge clk); #1;
        hold_reset_a();
    endtask

    typedef struct packed {
        logic [8*SW-1:0] s;
        logic [4*OW-1:0] ex0;
        logic [4*OW-1:0] ex2;
    } vec_t;
    vec_t vecs [3];

    int nexts, words, next_at, found, d_run;
    logic [OW-1:0] w0, w4;
    logic busy_r;

    initial begin
        vecs[0].s   = {12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
        vecs[0].ex0 = {16'd7, 16'd5, 16'd3, 16'd1};
        vecs[0].ex2 = {16'd8, 16'd6, 16'd4, 16'd2};
        vecs[1].s   = {12'hF00, 12'h123, 12'hFFE, 12'h000, 12'h001, 12'h800, 12'h7FF, 12'hFFF};
        vecs[1].ex0 = {16'h0123, 16'h0000, 16'hF800, 16'hFFFF};
        vecs[1].ex2 = {16'hFF00, 16'hFFFE, 16'h0001, 16'h07FF};
        vecs[2].s   = {12'hC00, 12'h400, 12'hF01, 12'h0FF, 12'h801, 12'h7FE, 12'hAAA, 12'h555};
        vecs[2].ex0 = {16'h0400, 16'h00FF, 16'h07FE, 16'h0555};
        vecs[2].ex2 = {16'hFC00, 16'hFF01, 16'hF801, 16'hFAAA};

        a_reset = 1'b1; a_valid = 1'b0; a_busy = 1'b0; a_in = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_busy = 1'b0; b_in = '0;
        @(negedge clk);
        chk("b_reset_outputs", {b_next, b_ovalid, b_overrun, |{b_x0, b_x1, b_x2, b_x3}}, 64'd0);
        reset_a();

        // Basic frame: 16 strobes 1..16, every second one accepted.
        nexts = 0; next_at = -1; words = 0;
        for (int i = 0; i < 28; i++) begin
            if (i < 16) step_a(1'b1, SW'(i + 1), 1'b0);
            else        step_a(1'b0, '0, 1'b0);
            if (a_next) begin
                nexts++;
                if (next_at < 0) next_at = i;
            end
            if (a_ovalid && words < 4) begin
                chk("basic_x0", a_x0, OW'(4 * words + 1));
                chk("basic_x2", a_x2, OW'(4 * words + 3));
                words++;
            end
        end
        chk("basic_next_count", nexts, 1);
        chk("basic_words", words, 4);
        chk("basic_latency", (next_at > 14) && (next_at - 14 <= 2), 1);

        // Busy downstream while three frames arrive: two banks kept, rest dropped.
        reset_a();
        nexts = 0;
        for (int i = 0; i < 49; i++) begin
            step_a(i < 48, SW'(i + 1), 1'b1);
            if (a_next) nexts++;
        end
        chk("busy_no_next", nexts, 0);
        chk("busy_overrun", a_overrun, 1);
        nexts = 0; words = 0; w0 = '0; w4 = '0;
        for (int i = 0; i < 40; i++) begin
            step_a(1'b0, '0, 1'b0);
            if (a_next) nexts++;
            if (a_ovalid) begin
                if (words == 0) w0 = a_x0;
                if (words == 4) w4 = a_x0;
                words++;
            end
        end
        chk("busy_next_count", nexts, 2);
        chk("busy_words", words, 8);
        chk("busy_oldest_first", w0, 16'd1);
        chk("busy_second_frame", w4, 16'd17);

        // Continuous input with release landing on or before the next bank's first sample.
        for (int d = 20; d <= 26; d++) begin
            reset_a();
            d_run = d; words = 0;
            for (int i = 0; i < 100; i++) begin
                step_a(i < 64, SW'($urandom), i < d_run);
                if (a_ovalid) words++;
            end
            chk("contig_words", words, 16);
            chk("contig_no_overrun", a_overrun, 0);
        end

        // Reset in the second STREAM cycle aborts the frame.
        reset_a();
        found = 0;
        for (int i = 0; i < 26 && found == 0; i++) begin
            step_a(i < 16, SW'(200 + i), 1'b0);
            if (a_ovalid) found = 1;
        end
        chk("abort_stream_seen", found, 1);
        @(posedge clk); #1;
        a_reset = 1'b1;
        #1;
        chk("abort_same_cycle", {a_ovalid, |{a_x0, a_x2}}, 64'd0);
        hold_reset_a();
        words = 0; w0 = '0;
        for (int i = 0; i < 30; i++) begin
            step_a(i < 16, SW'(300 + i), 1'b0);
            if (a_ovalid) begin
                if (words == 0) w0 = a_x0;
                words++;
            end
        end
        chk("abort_post_words", words, 4);
        chk("abort_post_first", w0, 16'd300);

        // Randomized traffic with busy bursts against the model.
        reset_a();
        busy_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) busy_r = ~busy_r;
            step_a($urandom_range(0, 3) != 0, SW'($urandom), busy_r);
        end
        for (int i = 0; i < 60; i++) step_a(1'b0, '0, 1'b0);
        chk("random_drained", frame_q.size(), 0);

        // DECIM=1 vector table: back-to-back samples all accepted, in order.
        @(posedge clk); #1; b_reset = 1'b0;
        foreach (vecs[e]) begin
            for (int j = 0; j < 8; j++) step_b(1'b1, vecs[e].s[j*SW +: SW]);
            words = 0;
            for (int k = 0; k < 16; k++) begin
                step_b(1'b0, '0);
                if (b_ovalid && words < 4) begin
                    chk("vec_x0", b_x0, vecs[e].ex0[words*OW +: OW]);
                    chk("vec_x2", b_x2, vecs[e].ex2[words*OW +: OW]);
                    chk("vec_imag", {b_x1, b_x3}, 64'd0);
                    words++;
                end
            end
            chk("vec_words", words, 4);
        end
        chk("vec_no_overrun", b_overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
